// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle for the scan driver: datapath inputs plus anode/segment pins and scan status.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_blank;
  logic [2:0]              brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [IW-1:0]           digit_idx;
  logic                    frame_tick;

  modport master (
    output en, digits, dp, blank, lz_blank, brightness,
    input  an, seg, dp_n, digit_idx, frame_tick
  );

  modport slave (
    input  en, digits, dp, blank, lz_blank, brightness,
    output an, seg, dp_n, digit_idx, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver: prescaler, digit scan, hex decode,
// per-digit and leading-zero blanking, PWM brightness, frame-synchronous input shadowing.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic                     clk,
  input logic                     rst,
  seven_seg_scan_driver_if.slave  bus
);
  localparam int PW   = $clog2(REFRESH_DIV);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int SLOT = REFRESH_DIV / 8;

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic                    load_pending;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    sh_lz;
  logic [2:0]              sh_bright;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_n_q;
  logic                    frame_tick_q;

  logic                    wrap, last, frame_end, load;
  logic [3:0]              nib;
  logic                    lz_hit, blanked, lit;
  logic [31:0]             on_lim;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    dp_n_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap      = (pre == PW'(REFRESH_DIV - 1));
    last      = (idx == IW'(NUM_DIGITS - 1));
    frame_end = bus.en && wrap && last;
    load      = bus.en && (load_pending || frame_end);

    nib = sh_digits[{idx, 2'b00} +: 4];
    // Leading zero: this nibble and everything above it is zero; digit 0 always shows.
    lz_hit  = sh_lz && (idx != '0) && ~|(sh_digits >> {idx, 2'b00});
    blanked = sh_blank[idx] || lz_hit;

    on_lim = (32'(sh_bright) + 32'd1) * 32'(SLOT);
    lit    = bus.en && (32'(pre) < on_lim) && !blanked;

    an_next   = '1;
    seg_next  = 7'h7F;
    dp_n_next = 1'b1;
    if (lit) begin
      an_next[idx] = 1'b0;
      seg_next     = hex7(nib);
      dp_n_next    = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      sh_digits    <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      sh_lz        <= 1'b0;
      sh_bright    <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      if (bus.en) begin
        pre <= wrap ? '0 : pre + PW'(1);
        if (wrap) idx <= last ? '0 : idx + IW'(1);
      end
      if (load) begin
        sh_digits    <= bus.digits;
        sh_dp        <= bus.dp;
        sh_blank     <= bus.blank;
        sh_lz        <= bus.lz_blank;
        sh_bright    <= bus.brightness;
        load_pending <= 1'b0;
      end
      an_q         <= an_next;
      seg_q        <= seg_next;
      dp_n_q       <= dp_n_next;
      frame_tick_q <= frame_end;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_tick = frame_tick_q;
endmodule
